// File: rtl/pipelined_exec_alu_pkg.sv
// Shared constants for the execute-stage ALU: op codes and FSM state encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pipelined_exec_alu_pkg;

    // alu_ctrl op codes; any code with bit 3 set decodes as OR
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_MOVE = 4'b0010;
    localparam logic [3:0] ALU_SWAP = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_MUL  = 4'b0111;

    // Execute FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/pipelined_exec_alu_if.sv
// Operand/result bus between ID/EX, the execute ALU and EX/MEM.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
// Signals: in_valid/in_ready/op1/op2/alu_ctrl/flush toward the ALU,
//          out_valid/out_ready/result/overflow from the ALU.
interface pipelined_exec_alu_if #(
    parameter int WIDTH = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       op1;
    logic [WIDTH-1:0]       op2;
    logic [3:0]             alu_ctrl;
    logic                   flush;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     result;
    logic                   overflow;

    // master: the pipeline driving operands and consuming results
    modport master (
        output in_valid, op1, op2, alu_ctrl, flush, out_ready,
        input  in_ready, out_valid, result, overflow
    );

    // slave: the ALU itself
    modport slave (
        input  in_valid, op1, op2, alu_ctrl, flush, out_ready,
        output in_ready, out_valid, result, overflow
    );
endinterface

// File: rtl/pipelined_exec_alu_seq_multiplier.sv
// Unsigned shift-add multiplier on operand magnitudes, one partial product per cycle.
// Latency: WIDTH cycles from i_start; o_done flags the cycle whose step is the last one.
// Backpressure: none; the caller starts it only when idle, i_flush aborts at any time.
// Ports: clk, rst, i_start, i_flush, i_a_mag/i_b_mag (WIDTH+1), o_busy, o_done, o_product (2*WIDTH).
module pipelined_exec_alu_seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic                 i_flush,
    input  logic [WIDTH:0]       i_a_mag,
    input  logic [WIDTH:0]       i_b_mag,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic                 r_busy;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH:0]       r_mplier;

    // Magnitudes never exceed 2^(WIDTH-1), so bit WIDTH of the multiplier is
    // always 0 and WIDTH steps cover every set bit.
    assign o_busy    = r_busy;
    assign o_done    = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
    assign o_product = r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_flush) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{(WIDTH-1){1'b0}}, i_a_mag};
            r_mplier <= i_b_mag;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (o_done) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pipelined_exec_alu.sv
// Registered, handshaked execute-stage ALU (ADD/SUB/MOVE/SWAP/AND/OR/XOR/signed MUL).
// Latency: 1 edge for single-cycle ops, WIDTH+1 edges for MUL.
// Backpressure: holds result while out_valid && !out_ready; in_ready low while busy, blocked or flushing.
// Ports: clk, rst (async, active-high), bus (slave modport: operands in, result/overflow out).
module pipelined_exec_alu #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pipelined_exec_alu_if.slave  bus
);
    import pipelined_exec_alu_pkg::*;

    logic [1:0]           r_state;
    logic                 r_out_valid;
    logic                 r_overflow;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_result;

    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_is_mul;
    logic                 w_sign1;
    logic                 w_sign2;
    logic [WIDTH:0]       w_mag1;
    logic [WIDTH:0]       w_mag2;
    logic [WIDTH-1:0]     w_sum;
    logic [WIDTH-1:0]     w_diff;
    logic [WIDTH-1:0]     w_lo;
    logic [WIDTH-1:0]     w_hi;
    logic                 w_ovf;
    logic                 w_mul_busy;
    logic                 w_mul_done;
    logic [2*WIDTH-1:0]   w_product;
    logic [2*WIDTH-1:0]   w_fix_res;
    logic                 w_fix_ovf;

    assign w_in_ready = (r_state == ST_IDLE) && !w_mul_busy
                        && (!r_out_valid || bus.out_ready) && !bus.flush;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_is_mul   = (bus.alu_ctrl == ALU_MUL);

    // Magnitudes carry one extra bit so the most-negative operand is exact.
    assign w_sign1 = bus.op1[WIDTH-1];
    assign w_sign2 = bus.op2[WIDTH-1];
    assign w_mag1  = w_sign1 ? -{1'b1, bus.op1} : {1'b0, bus.op1};
    assign w_mag2  = w_sign2 ? -{1'b1, bus.op2} : {1'b0, bus.op2};

    assign w_sum  = bus.op1 + bus.op2;
    assign w_diff = bus.op1 - bus.op2;

    always_comb begin
        w_lo  = '0;
        w_hi  = '0;
        w_ovf = 1'b0;
        case (bus.alu_ctrl)
            ALU_ADD: begin
                w_lo  = w_sum;
                w_ovf = (w_sign1 == w_sign2) && (w_sum[WIDTH-1] != w_sign1);
            end
            ALU_SUB: begin
                // true signed overflow, not the borrow out
                w_lo  = w_diff;
                w_ovf = (w_sign1 != w_sign2) && (w_diff[WIDTH-1] != w_sign1);
            end
            ALU_MOVE: w_lo = bus.op2;
            ALU_SWAP: begin
                w_hi = bus.op1;
                w_lo = bus.op2;
            end
            ALU_AND:  w_lo = bus.op1 & bus.op2;
            ALU_OR:   w_lo = bus.op1 | bus.op2;
            ALU_XOR:  w_lo = bus.op1 ^ bus.op2;
            ALU_MUL:  w_lo = '0;
            default:  w_lo = bus.op1 | bus.op2;
        endcase
    end

    pipelined_exec_alu_seq_multiplier #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_accept && w_is_mul),
        .i_flush   (bus.flush),
        .i_a_mag   (w_mag1),
        .i_b_mag   (w_mag2),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    // Sign fixup; product fits WIDTH signed bits only if hi is the sign extension of lo.
    assign w_fix_res = r_neg ? -w_product : w_product;
    assign w_fix_ovf = (w_fix_res[2*WIDTH-1:WIDTH] != {WIDTH{w_fix_res[WIDTH-1]}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_neg       <= 1'b0;
            r_result    <= '0;
        end else if (bus.flush) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_out_valid && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                    // a single-cycle accept reloads in the same edge the old result drains
                    if (w_accept) begin
                        if (w_is_mul) begin
                            r_state <= ST_MUL;
                            r_neg   <= w_sign1 ^ w_sign2;
                        end else begin
                            r_result    <= {w_hi, w_lo};
                            r_overflow  <= w_ovf;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (w_mul_done) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_result    <= w_fix_res;
                    r_overflow  <= w_fix_ovf;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_pipelined_exec_alu.sv
// Directed bench for pipelined_exec_alu at WIDTH=16 (scoreboarded) and WIDTH=8.
// Latency: checks 1-edge single ops and WIDTH+1-edge MUL.
// Backpressure: exercises out_ready hold, same-edge reload, flush and async reset.
module tb_pipelined_exec_alu;
    import pipelined_exec_alu_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [32:0] sb[$];
    logic [3:0]  b2b_ops[4];
    logic [15:0] hold_res;
    bit          flag;
    int          n;

    pipelined_exec_alu_if #(.WIDTH(16)) b16();
    pipelined_exec_alu_if #(.WIDTH(8))  b8();

    pipelined_exec_alu #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
    pipelined_exec_alu #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference model on plain integers: {overflow, result} with result masked to 2*w bits.
    function automatic logic [32:0] model(input int w, input logic [3:0] ctrl,
                                          input longint a, input longint b);
        longint m, mx, mn, s, lo, hi;
        logic   ovf;
        logic [63:0] r;
        m   = (longint'(1) << w) - 1;
        mx  = (longint'(1) << (w - 1)) - 1;
        mn  = -mx - 1;
        lo  = 0;
        hi  = 0;
        s   = 0;
        ovf = 1'b0;
        case (ctrl)
            4'd0: begin s = a + b; lo = s & m; ovf = (s > mx) || (s < mn); end
            4'd1: begin s = a - b; lo = s & m; ovf = (s > mx) || (s < mn); end
            4'd2: lo = b & m;
            4'd3: begin hi = a & m; lo = b & m; end
            4'd4: lo = (a & b) & m;
            4'd5: lo = (a | b) & m;
            4'd6: lo = (a ^ b) & m;
            4'd7: begin s = a * b; lo = s & m; hi = (s >>> w) & m; ovf = (s > mx) || (s < mn); end
            default: lo = (a | b) & m;
        endcase
        r = 64'((hi << w) | lo);
        return {ovf, r[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge on the 16-bit DUT with scoreboard bookkeeping for that edge.
    task automatic cyc();
        logic [32:0] e;
        #1;
        if (b16.out_valid && b16.out_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL sb_underflow observed=empty expected=entry");
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_result", 64'(b16.result), 64'(e[31:0]));
                chk("sb_overflow", 64'(b16.overflow), 64'(e[32]));
            end
        end
        if (b16.in_valid && b16.in_ready) begin
            sb.push_back(model(16, b16.alu_ctrl, longint'($signed(b16.op1)),
                               longint'($signed(b16.op2))));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive16(input logic [3:0] ctrl, input logic [15:0] a, input logic [15:0] b);
        b16.in_valid = 1'b1;
        b16.alu_ctrl = ctrl;
        b16.op1      = a;
        b16.op2      = b;
    endtask

    task automatic mul_run16(input logic [15:0] a, input logic [15:0] b, input string tag);
        int  cnt;
        bit  ir_hi;
        drive16(ALU_MUL, a, b);
        cyc();
        b16.in_valid = 1'b0;
        cnt   = 0;
        ir_hi = 1'b0;
        while (!b16.out_valid && cnt < 40) begin
            if (b16.in_ready) ir_hi = 1'b1;
            cyc();
            cnt++;
        end
        chk({tag, "_latency"}, 64'(cnt), 64'd17);
        chk({tag, "_in_ready_low"}, 64'(ir_hi), 64'd0);
    endtask

    task automatic run8(input logic [3:0] ctrl, input logic [7:0] a, input logic [7:0] b,
                        input int lat, input string tag);
        int          cnt;
        logic [32:0] e;
        e = model(8, ctrl, longint'($signed(a)), longint'($signed(b)));
        b8.in_valid = 1'b1;
        b8.alu_ctrl = ctrl;
        b8.op1      = a;
        b8.op2      = b;
        #1;
        chk({tag, "_in_ready"}, 64'(b8.in_ready), 64'd1);
        @(posedge clk);
        #1;
        b8.in_valid = 1'b0;
        cnt = 0;
        while (!b8.out_valid && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk({tag, "_latency"}, 64'(cnt), 64'(lat));
        chk({tag, "_result"}, 64'(b8.result), 64'(e[15:0]));
        chk({tag, "_overflow"}, 64'(b8.overflow), 64'(e[32]));
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        b2b_ops  = '{ALU_AND, ALU_OR, ALU_XOR, 4'b1010};
        rst = 1'b1;
        b16.in_valid = 1'b0; b16.op1 = '0; b16.op2 = '0; b16.alu_ctrl = '0;
        b16.flush = 1'b0; b16.out_ready = 1'b1;
        b8.in_valid = 1'b0; b8.op1 = '0; b8.op2 = '0; b8.alu_ctrl = '0;
        b8.flush = 1'b0; b8.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        chk("rst_out_valid", 64'(b16.out_valid), 64'd0);
        chk("rst_result", 64'(b16.result), 64'd0);
        chk("rst_overflow", 64'(b16.overflow), 64'd0);
        chk("rst_w8_out_valid", 64'(b8.out_valid), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(b16.in_ready), 64'd1);

        // ADD
        drive16(ALU_ADD, 16'h7FFF, 16'h0001);
        cyc();
        chk("add_ovf_valid", 64'(b16.out_valid), 64'd1);
        chk("add_ovf_result", 64'(b16.result), 64'h0000_8000);
        chk("add_ovf_flag", 64'(b16.overflow), 64'd1);
        drive16(ALU_ADD, 16'h0003, 16'hFFFF);
        cyc();
        chk("add_result", 64'(b16.result), 64'h0000_0002);
        chk("add_flag", 64'(b16.overflow), 64'd0);

        // SUB
        drive16(ALU_SUB, 16'h8000, 16'h0001);
        cyc();
        chk("sub_ovf_result", 64'(b16.result), 64'h0000_7FFF);
        chk("sub_ovf_flag", 64'(b16.overflow), 64'd1);
        drive16(ALU_SUB, 16'h0001, 16'h0002);
        cyc();
        chk("sub_result", 64'(b16.result), 64'h0000_FFFF);
        chk("sub_noborrow_flag", 64'(b16.overflow), 64'd0);

        // SWAP, MOVE
        drive16(ALU_SWAP, 16'h1234, 16'hABCD);
        cyc();
        chk("swap_result", 64'(b16.result), 64'h1234_ABCD);
        drive16(ALU_MOVE, 16'h5555, 16'h8421);
        cyc();

        // back-to-back logic ops at one per cycle
        for (int i = 0; i < 4; i++) begin
            drive16(b2b_ops[i], 16'($urandom), 16'($urandom));
            #1;
            chk("b2b_in_ready", 64'(b16.in_ready), 64'd1);
            cyc();
            chk("b2b_out_valid", 64'(b16.out_valid), 64'd1);
        end
        b16.in_valid = 1'b0;
        cyc();
        chk("drain_out_valid", 64'(b16.out_valid), 64'd0);

        // MUL
        mul_run16(16'hFFFD, 16'h0007, "mul_neg");
        chk("mul_neg_result", 64'(b16.result), 64'hFFFF_FFEB);
        chk("mul_neg_flag", 64'(b16.overflow), 64'd0);
        mul_run16(16'h4000, 16'h0004, "mul_big");
        chk("mul_big_result", 64'(b16.result), 64'h0001_0000);
        chk("mul_big_flag", 64'(b16.overflow), 64'd1);
        mul_run16(16'h8000, 16'h8000, "mul_min");
        chk("mul_min_result", 64'(b16.result), 64'h4000_0000);
        mul_run16(16'h0000, 16'h1234, "mul_zero");
        mul_run16(16'($urandom), 16'($urandom), "mul_rand");
        b16.in_valid = 1'b0;
        cyc();

        // backpressure hold, then release with a same-edge reload
        b16.out_ready = 1'b0;
        drive16(ALU_ADD, 16'h0001, 16'h0002);
        cyc();
        drive16(ALU_AND, 16'hF0F0, 16'hFF00);
        hold_res = b16.result[15:0];
        flag = 1'b0;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (b16.result[15:0] !== hold_res || b16.out_valid !== 1'b1) flag = 1'b1;
            if (b16.in_ready !== 1'b0) n++;
            cyc();
        end
        chk("bp_stable", 64'(flag), 64'd0);
        chk("bp_in_ready_low", 64'(n), 64'd0);
        b16.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(b16.in_ready), 64'd1);
        cyc();
        chk("bp_reload_valid", 64'(b16.out_valid), 64'd1);
        chk("bp_reload_result", 64'(b16.result), 64'h0000_F000);
        b16.in_valid = 1'b0;
        cyc();
        chk("bp_release_drop", 64'(b16.out_valid), 64'd0);

        // flush at counter=5 of a MUL
        drive16(ALU_MUL, 16'h0005, 16'h0006);
        cyc();
        b16.in_valid = 1'b0;
        repeat (5) cyc();
        b16.flush = 1'b1;
        cyc();
        b16.flush = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("flush_in_ready", 64'(b16.in_ready), 64'd1);
        chk("flush_out_valid", 64'(b16.out_valid), 64'd0);
        flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (b16.out_valid) flag = 1'b1;
            cyc();
        end
        chk("flush_no_result", 64'(flag), 64'd0);
        drive16(ALU_ADD, 16'h7000, 16'h7000);
        cyc();
        chk("post_flush_result", 64'(b16.result), 64'h0000_E000);
        chk("post_flush_flag", 64'(b16.overflow), 64'd1);
        b16.in_valid = 1'b0;
        cyc();

        // asynchronous reset between edges, mid-MUL
        drive16(ALU_MUL, 16'h0009, 16'h0009);
        cyc();
        b16.in_valid = 1'b0;
        repeat (3) cyc();
        void'(sb.pop_back());
        #3;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(b16.out_valid), 64'd0);
        chk("arst_result", 64'(b16.result), 64'd0);
        chk("arst_overflow", 64'(b16.overflow), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_in_ready", 64'(b16.in_ready), 64'd1);
        flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (b16.out_valid) flag = 1'b1;
            cyc();
        end
        chk("arst_no_result", 64'(flag), 64'd0);

        // WIDTH=8 instance
        run8(ALU_MUL, 8'hFD, 8'h07, 9, "w8_mul_neg");
        chk("w8_mul_neg_const", 64'(b8.result), 64'h0000_FFEB);
        run8(ALU_ADD, 8'h7F, 8'h01, 0, "w8_add");
        run8(ALU_MUL, 8'h80, 8'h80, 9, "w8_mul_min");

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
